// File: rtl/ps2_mem_arbiter.sv
// Shares one memory port between VGA fetch and a PS/2 scancode FIFO that writes to a fixed word.
// Optional macro STARVE_TIMEOUT_EN forces a write after TIMEOUT arbitration cycles.
module ps2_mem_arbiter #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [9:0] PS2_ADDR   = 10'h3FF,
    parameter int         TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    ps2_data,
    input  logic                          ps2_valid,
    input  logic                          vga_req,
    input  logic [9:0]                    vga_addr,
    output logic [9:0]                    mem_addr,
    output logic [15:0]                   mem_din,
    output logic                          mem_we,
    output logic                          vga_stall,
    output logic                          ps2_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARB   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q;
    logic          push, pop, arb_go;

    assign push = ps2_valid && (count_q < DEPTH_C);
    // WRITE is only reachable with a non-empty FIFO, so popping here never underflows.
    assign pop  = (state_q == S_WRITE);

`ifdef STARVE_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT - 1);

    logic [WW-1:0] wait_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (state_q == S_ARB) begin
            wait_q <= wait_q + WW'(1);
        end else begin
            wait_q <= '0;
        end
    end

    assign arb_go    = !vga_req || (wait_q == TO_LAST);
    assign vga_stall = (state_q == S_WRITE) && vga_req;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign arb_go    = !vga_req;
    assign vga_stall = 1'b0;
`endif

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_ARB;
            S_ARB:   if (arb_go) state_d = S_WRITE;
            S_WRITE: state_d = (count_d != '0) ? S_ARB : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= ps2_data;
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (ps2_valid && !push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign mem_we     = pop;
    assign mem_addr   = pop ? PS2_ADDR : vga_addr;
    assign mem_din    = {8'h00, fifo_q[rd_ptr_q]};
    assign fifo_count = count_q;
    assign ps2_ovf    = ovf_q;

endmodule

// File: tb/tb_ps2_mem_arbiter.sv
// Directed bench for ps2_mem_arbiter: per-cycle vector table plus reset and timeout sequences.
module tb_ps2_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ps2_data;
    logic        ps2_valid;
    logic        vga_req;
    logic [9:0]  vga_addr;
    logic [9:0]  mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;
    logic        vga_stall;
    logic        ps2_ovf;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ps2_mem_arbiter #(
        .FIFO_DEPTH (4),
        .PS2_ADDR   (10'h3FF),
        .TIMEOUT    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_data   (ps2_data),
        .ps2_valid  (ps2_valid),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .vga_stall  (vga_stall),
        .ps2_ovf    (ps2_ovf),
        .fifo_count (fifo_count)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        req;
        logic        we;
        logic [15:0] din;
        logic [2:0]  cnt;
        logic        ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [7:0] d, input logic req,
                       input logic we, input logic [15:0] din,
                       input logic [2:0] cnt, input logic ovf);
        vec_t e;
        e.v = v; e.d = d; e.req = req; e.we = we; e.din = din; e.cnt = cnt; e.ovf = ovf;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic req, input logic [9:0] a);
        @(negedge clk);
        ps2_valid = v;
        ps2_data  = d;
        vga_req   = req;
        vga_addr  = a;
        #1;
    endtask

    initial begin
        logic [9:0] a;

        // single write
        add(1, 8'h1C, 0, 0, 16'h0000, 0, 0);
        add(0, 8'h00, 0, 0, 16'h0000, 1, 0);
        add(0, 8'h00, 0, 0, 16'h0000, 1, 0);
        add(0, 8'h00, 0, 1, 16'h001C, 1, 0);
        add(0, 8'h00, 0, 0, 16'h0000, 0, 0);
        add(0, 8'h00, 0, 0, 16'h0000, 0, 0);
        // blocking then back-to-back drain
        add(1, 8'h1C, 1, 0, 16'h0000, 0, 0);
        add(1, 8'hF0, 1, 0, 16'h0000, 1, 0);
        add(0, 8'h00, 1, 0, 16'h0000, 2, 0);
        add(0, 8'h00, 1, 0, 16'h0000, 2, 0);
        add(0, 8'h00, 0, 0, 16'h0000, 2, 0);
        add(0, 8'h00, 0, 1, 16'h001C, 2, 0);
        add(0, 8'h00, 0, 0, 16'h0000, 1, 0);
        add(0, 8'h00, 0, 1, 16'h00F0, 1, 0);
        add(0, 8'h00, 0, 0, 16'h0000, 0, 0);
        // overflow with pointer wrap
        add(1, 8'h01, 1, 0, 16'h0000, 0, 0);
        add(1, 8'h02, 1, 0, 16'h0000, 1, 0);
        add(1, 8'h03, 1, 0, 16'h0000, 2, 0);
        add(1, 8'h04, 1, 0, 16'h0000, 3, 0);
        add(1, 8'h05, 1, 0, 16'h0000, 4, 0);
        add(1, 8'h06, 1, 0, 16'h0000, 4, 1);
        add(0, 8'h00, 1, 0, 16'h0000, 4, 1);
        add(0, 8'h00, 0, 0, 16'h0000, 4, 1);
        add(0, 8'h00, 0, 1, 16'h0001, 4, 1);
        add(0, 8'h00, 0, 0, 16'h0000, 3, 1);
        add(0, 8'h00, 0, 1, 16'h0002, 3, 1);
        add(0, 8'h00, 0, 0, 16'h0000, 2, 1);
        add(0, 8'h00, 0, 1, 16'h0003, 2, 1);
        add(0, 8'h00, 0, 0, 16'h0000, 1, 1);
        add(0, 8'h00, 0, 1, 16'h0004, 1, 1);
        add(0, 8'h00, 0, 0, 16'h0000, 0, 1);
        add(0, 8'h00, 0, 0, 16'h0000, 0, 1);
        // push and pop on the same edge
        add(1, 8'hAA, 1, 0, 16'h0000, 0, 1);
        add(1, 8'hBB, 1, 0, 16'h0000, 1, 1);
        add(0, 8'h00, 0, 0, 16'h0000, 2, 1);
        add(1, 8'hCC, 0, 1, 16'h00AA, 2, 1);
        add(0, 8'h00, 0, 0, 16'h0000, 2, 1);
        add(0, 8'h00, 0, 1, 16'h00BB, 2, 1);
        add(0, 8'h00, 0, 0, 16'h0000, 1, 1);
        add(0, 8'h00, 0, 1, 16'h00CC, 1, 1);
        add(0, 8'h00, 0, 0, 16'h0000, 0, 1);

        rst_n     = 1'b0;
        ps2_valid = 1'b0;
        ps2_data  = 8'h00;
        vga_req   = 1'b0;
        vga_addr  = 10'h055;
        #1;
        chk("reset.we",    mem_we,     0);
        chk("reset.addr",  mem_addr,   10'h055);
        chk("reset.cnt",   fifo_count, 0);
        chk("reset.ovf",   ps2_ovf,    0);
        chk("reset.stall", vga_stall,  0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            a = 10'h100 + 10'(i);
            drive(tbl[i].v, tbl[i].d, tbl[i].req, a);
            chk($sformatf("v%0d.we", i),    mem_we,     tbl[i].we);
            chk($sformatf("v%0d.addr", i),  mem_addr,   tbl[i].we ? 10'h3FF : a);
            chk($sformatf("v%0d.cnt", i),   fifo_count, tbl[i].cnt);
            chk($sformatf("v%0d.ovf", i),   ps2_ovf,    tbl[i].ovf);
            chk($sformatf("v%0d.stall", i), vga_stall,  0);
            if (tbl[i].we) chk($sformatf("v%0d.din", i), mem_din, tbl[i].din);
        end

        // asynchronous reset during a WRITE with two bytes queued and ovf set
        drive(1, 8'h55, 0, 10'h200);
        drive(1, 8'h66, 0, 10'h201);
        drive(0, 8'h00, 0, 10'h202);
        drive(0, 8'h00, 0, 10'h203);
        chk("rstw.pre_we",  mem_we,     1);
        chk("rstw.pre_din", mem_din,    16'h0055);
        chk("rstw.pre_cnt", fifo_count, 2);
        chk("rstw.pre_ovf", ps2_ovf,    1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw.we",    mem_we,     0);
        chk("rstw.addr",  mem_addr,   10'h203);
        chk("rstw.cnt",   fifo_count, 0);
        chk("rstw.ovf",   ps2_ovf,    0);
        chk("rstw.stall", vga_stall,  0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 8'h00, 0, 10'h204);
        chk("rstw.post_cnt", fifo_count, 0);
        chk("rstw.post_we",  mem_we,     0);

        // starvation: vga_req held high with one byte queued
        drive(1, 8'h77, 1, 10'h300);
        for (int k = 1; k <= 30; k++) begin
            drive(0, 8'h00, 1, 10'h300 + 10'(k));
`ifdef STARVE_TIMEOUT_EN
            chk($sformatf("to%0d.we", k),    mem_we,    (k == 18));
            chk($sformatf("to%0d.stall", k), vga_stall, (k == 18));
            if (k == 18) chk("to.din", mem_din, 16'h0077);
`else
            chk($sformatf("to%0d.we", k),    mem_we,    0);
            chk($sformatf("to%0d.stall", k), vga_stall, 0);
            chk($sformatf("to%0d.addr", k),  mem_addr,  10'h300 + 10'(k));
`endif
        end
`ifndef STARVE_TIMEOUT_EN
        drive(0, 8'h00, 0, 10'h31F);
        chk("rel.we_arb", mem_we, 0);
        drive(0, 8'h00, 0, 10'h320);
        chk("rel.we",    mem_we,   1);
        chk("rel.din",   mem_din,  16'h0077);
        chk("rel.addr",  mem_addr, 10'h3FF);
        drive(0, 8'h00, 0, 10'h321);
        chk("rel.cnt",   fifo_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_mem_arbiter.md
PS2_MEM_ARBITER -- requirements
Module: ps2_mem_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the scancode buffer depth in bytes (power of 2, range 2..16).
REQ-002 Parameter PS2_ADDR, default 10'h3FF, SHALL set the fixed memory word that receives keyboard bytes.
REQ-003 Parameter TIMEOUT, default 16, SHALL set the maximum number of ARB-state cycles before a write is forced (used only under REQ-025).
REQ-004 clk  in  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 ps2_data  in  8  SHALL be the received scancode byte.
REQ-007 ps2_valid  in  1  SHALL be a one-cycle strobe qualifying ps2_data.
REQ-008 vga_req  in  1  SHALL indicate that the VGA fetch owns memory this cycle.
REQ-009 vga_addr  in  10  SHALL be the VGA fetch address.
REQ-010 mem_addr  out  10  SHALL be the shared memory address.
REQ-011 mem_din  out  16  SHALL be the write data, {8'h00, FIFO head byte}.
REQ-012 mem_we  out  1  SHALL be the memory write enable.
REQ-013 vga_stall  out  1  SHALL flag a cycle in which a VGA fetch was overridden.
REQ-014 ps2_ovf  out  1  SHALL be a sticky overflow flag.
REQ-015 fifo_count  out  $clog2(FIFO_DEPTH)+1  SHALL be the current FIFO occupancy.

Function
REQ-016 The FIFO SHALL push ps2_data on every rising edge where ps2_valid=1 and fifo_count<FIFO_DEPTH.
REQ-017 ps2_valid=1 while the FIFO is full SHALL drop the byte, leave FIFO contents unchanged, and set ps2_ovf=1 until reset.
REQ-018 The FSM SHALL have three states: IDLE, ARB and WRITE.
REQ-019 IDLE SHALL go to ARB when fifo_count>0, and SHALL otherwise remain in IDLE.
REQ-020 ARB SHALL go to WRITE when vga_req=0, and SHALL otherwise remain in ARB.
REQ-021 WRITE SHALL last exactly one cycle, pop the FIFO head at its closing edge, then go to ARB if the post-pop count is >0, else to IDLE.
REQ-022 Outputs SHALL be combinational from state, as follows:
- In WRITE: mem_addr=PS2_ADDR, mem_we=1, mem_din=head.
- In all other states: mem_addr=vga_addr, mem_we=0, mem_din=head (don't-care).
REQ-023 Simultaneous push and pop on the same edge SHALL both take effect, leaving fifo_count unchanged; bytes SHALL pop in arrival order.
REQ-024 Minimum latency SHALL be as follows: a strobe in cycle N into an empty FIFO with vga_req=0 SHALL give mem_we=1 in cycle N+3 (IDLE at N+1, ARB at N+2); read and write pointers SHALL wrap modulo FIFO_DEPTH.

Configuration
REQ-025 With STARVE_TIMEOUT_EN defined, the starvation timeout SHALL apply:
- A wait counter SHALL clear on ARB entry and increment each ARB cycle.
- When it reaches TIMEOUT-1, the FSM SHALL enter WRITE regardless of vga_req.
- vga_stall=1 SHALL be asserted during that WRITE cycle if vga_req=1.
REQ-026 Without STARVE_TIMEOUT_EN, ARB SHALL wait indefinitely for vga_req=0, vga_stall SHALL be tied 0, and no wait counter SHALL be built.

Reset
REQ-027 rst_n=0 SHALL, asynchronously and at any point including mid-WRITE, force the following:
- state=IDLE, FIFO empty, fifo_count=0, ps2_ovf=0, wait counter=0;
- hence mem_we=0, vga_stall=0, mem_addr=vga_addr.
REQ-028 No push or pop SHALL occur on an edge where rst_n=0; normal operation SHALL resume on the first rising edge after deassertion.

Verification
REQ-029 Single write: reset, vga_req=0, strobe 8'h1C at cycle 0 -> mem_we=1, mem_addr=10'h3FF, mem_din=16'h001C at cycle 3 only.
REQ-030 Blocking: vga_req=1 held, strobes 8'h1C and 8'hF0 -> no writes, mem_addr tracks vga_addr; release vga_req -> writes 16'h001C then 16'h00F0, consecutive WRITE/ARB/WRITE.
REQ-031 Overflow: vga_req=1, six strobes (8'h01..8'h06) with FIFO_DEPTH=4 -> fifo_count=4, ps2_ovf=1; release -> writes 8'h01..8'h04 only.
REQ-032 Push/pop coincidence: strobe arrives in a WRITE cycle with count=2 -> fifo_count stays 2, order preserved.
REQ-033 Timeout (macro defined, TIMEOUT=16): vga_req=1 held, one strobe -> WRITE 16 cycles after ARB entry, vga_stall=1 for that cycle; macro undefined -> no write while vga_req=1.
REQ-034 Reset mid-WRITE: drop rst_n during WRITE -> mem_we falls without a clock edge, fifo_count=0, ps2_ovf=0.
